// File: rtl/vga_pkg.sv
// Shared types and 640x480@60 timing defaults for the VGA scan driver.
package vga_pkg;

   // 640x480@60 timing, counted in pixel-clock ticks and lines
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   // Per-pixel position tag that travels alongside the renderer pipeline
   typedef struct packed {
      logic active;
      logic hs_n;
      logic vs_n;
   } vga_tag_t;

   // Idle tag: blanked, both syncs de-asserted
   localparam vga_tag_t VGA_TAG_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

   // Counter width able to hold 0..total-1, never narrower than one bit
   function automatic int cnt_width(input int total);
      return (total <= 2) ? 1 : $clog2(total);
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register; DEPTH=0 collapses to a plain wire.
module vga_delay_line #(
   parameter int             W       = 1,
   parameter int             DEPTH   = 0,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_wire
         // No stages: the clock, reset and enable are intentionally unused
         logic unused_ctrl;
         assign unused_ctrl = &{1'b0, clk, rst_n, en};
         assign q = d;
      end else begin : g_shift
         // tap[i] is the input of stage i; tap[DEPTH] is the line output
         logic [(DEPTH+1)*W-1:0] tap;
         assign tap[W-1:0] = d;

         for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [W-1:0] stage_q;
            logic [W-1:0] stage_d;

            // Shift one place on each enabled tick, otherwise hold
            always_comb begin
               stage_d = stage_q;
               if (en) begin
                  stage_d = tap[gi*W +: W];
               end
            end

            // Stage register, reset to the idle value
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  stage_q <= RST_VAL;
               end else begin
                  stage_q <= stage_d;
               end
            end

            assign tap[(gi+1)*W +: W] = stage_q;
         end

         assign q = tap[DEPTH*W +: W];
      end
   endgenerate

endmodule

// File: rtl/vga_scan_driver.sv
// VGA raster generator: scan counters, sync/blank decode, pipeline-matched
// output registers for RGB and syncs, and line/frame strobes.
module vga_scan_driver
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int PIPE_DLY = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pix_ce,
   output logic [31:0] row,
   output logic [31:0] col,
   input  logic [3:0]  pix_r,
   input  logic [3:0]  pix_g,
   input  logic [3:0]  pix_b,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        video_on,
   output logic        line_start,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = cnt_width(H_TOTAL);
   localparam int VW      = cnt_width(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

   // Decode boundaries kept at 32 bits so a zero back porch cannot overflow
   localparam logic [31:0] H_ACT_END = 32'(H_ACTIVE);
   localparam logic [31:0] HS_START  = 32'(H_ACTIVE + H_FP);
   localparam logic [31:0] HS_END    = 32'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [31:0] V_ACT_END = 32'(V_ACTIVE);
   localparam logic [31:0] VS_START  = 32'(V_ACTIVE + V_FP);
   localparam logic [31:0] VS_END    = 32'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic          h_wrap, v_wrap;
   logic [31:0]   h_ext, v_ext;

   vga_tag_t tag_now;
   vga_tag_t tag_dly;

   rgb444_t  rgb_q, rgb_d;
   logic     hs_q, hs_d;
   logic     vs_q, vs_d;
   logic     video_on_q, video_on_d;
   logic     line_start_q, line_start_d;
   logic     frame_start_q, frame_start_d;

   // Next scan position: advance on pix_ce, wrap exactly at the last pixel/line
   always_comb begin
      h_wrap  = (h_cnt_q == H_LAST);
      v_wrap  = (v_cnt_q == V_LAST);
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (pix_ce) begin
         if (h_wrap) begin
            h_cnt_d = '0;
            v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
         end else begin
            h_cnt_d = h_cnt_q + HW'(1);
         end
      end
   end

   // Scan counters; reset aborts the frame and restarts at (0,0)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // The counters are themselves registers, so row/col are glitch-free copies
   assign col = 32'(h_cnt_q);
   assign row = 32'(v_cnt_q);

   // Position decode for the pixel currently presented to the renderer
   always_comb begin
      h_ext          = 32'(h_cnt_q);
      v_ext          = 32'(v_cnt_q);
      tag_now        = VGA_TAG_IDLE;
      tag_now.active = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
      tag_now.hs_n   = !((h_ext >= HS_START) && (h_ext < HS_END));
      tag_now.vs_n   = !((v_ext >= VS_START) && (v_ext < VS_END));
   end

   // Tags wait out the renderer latency so they line up with pix_*
   vga_delay_line #(
      .W       ($bits(vga_tag_t)),
      .DEPTH   (PIPE_DLY),
      .RST_VAL (VGA_TAG_IDLE)
   ) u_tag_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (pix_ce),
      .d     (tag_now),
      .q     (tag_dly)
   );

   // Pin values: colour gated by the delayed active tag, strobes on wrap ticks only
   always_comb begin
      rgb_d         = rgb_q;
      hs_d          = hs_q;
      vs_d          = vs_q;
      video_on_d    = video_on_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (pix_ce) begin
         rgb_d         = tag_dly.active ? '{r: pix_r, g: pix_g, b: pix_b} : '0;
         hs_d          = tag_dly.hs_n;
         vs_d          = tag_dly.vs_n;
         video_on_d    = tag_dly.active;
         line_start_d  = h_wrap;
         frame_start_d = h_wrap && v_wrap;
      end
   end

   // Output registers: everything reaches the pins on the same tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_q         <= '0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         video_on_q    <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         rgb_q         <= rgb_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         video_on_q    <= video_on_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga_r       = rgb_q.r;
   assign vga_g       = rgb_q.g;
   assign vga_b       = rgb_q.b;
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign video_on    = video_on_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Directed bench: two reduced-timing instances.
//  dut_a: H 8/2/2/2 (14), V 4/1/1/1 (7), PIPE_DLY 0, pix_ce driven by the bench.
//  dut_b: H 16/2/4/2 (24), V 6/1/2/1 (10), PIPE_DLY 2, pix_ce every 2nd clk,
//         renderer returns col[3:0] two ticks late.
module tb_vga_scan_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;

   logic        pix_ce_a;
   logic [3:0]  pix_r_a, pix_g_a, pix_b_a;
   logic [31:0] row_a, col_a;
   logic [3:0]  vga_r_a, vga_g_a, vga_b_a;
   logic        hs_a, vs_a, von_a, ls_a, fs_a;

   logic        pix_ce_b;
   logic [3:0]  pix_r_b, pix_g_b, pix_b_b;
   logic [31:0] row_b, col_b;
   logic [3:0]  vga_r_b, vga_g_b, vga_b_b;
   logic        hs_b, vs_b, von_b, ls_b, fs_b;

   int errors, checks;
   int n_a, k_b, clk_i;
   int h1, h2;
   int last_ls_b, last_fs_b;
   int hs_low, vs_low, guard, cnt;

   vga_scan_driver #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .PIPE_DLY(0)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce_a),
      .row(row_a), .col(col_a),
      .pix_r(pix_r_a), .pix_g(pix_g_a), .pix_b(pix_b_a),
      .vga_r(vga_r_a), .vga_g(vga_g_a), .vga_b(vga_b_a),
      .vga_hs(hs_a), .vga_vs(vs_a), .video_on(von_a),
      .line_start(ls_a), .frame_start(fs_a)
   );

   vga_scan_driver #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .PIPE_DLY(2)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce_b),
      .row(row_b), .col(col_b),
      .pix_r(pix_r_b), .pix_g(pix_g_b), .pix_b(pix_b_b),
      .vga_r(vga_r_b), .vga_g(vga_g_b), .vga_b(vga_b_b),
      .vga_hs(hs_b), .vga_vs(vs_b), .video_on(von_b),
      .line_start(ls_b), .frame_start(fs_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected pins of dut_a after n_a ticks: pins show position n_a-1
   task automatic check_a(input logic ce);
      int p, h, v;
      logic act, e_hs, e_vs;
      if (n_a == 0) begin
         act = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
      end else begin
         p    = n_a - 1;
         h    = p % 14;
         v    = (p / 14) % 7;
         act  = (h < 8) && (v < 4);
         e_hs = !((h >= 10) && (h < 12));
         e_vs = !(v == 5);
      end
      chk("a_col", col_a, n_a % 14);
      chk("a_row", row_a, (n_a / 14) % 7);
      chk("a_hs", hs_a, e_hs);
      chk("a_vs", vs_a, e_vs);
      chk("a_video_on", von_a, act);
      chk("a_r", vga_r_a, act ? 4'hF : 4'h0);
      chk("a_g", vga_g_a, act ? 4'hA : 4'h0);
      chk("a_b", vga_b_a, act ? 4'h3 : 4'h0);
      chk("a_line_start", ls_a, ce && (n_a > 0) && (n_a % 14 == 0));
      chk("a_frame_start", fs_a, ce && (n_a > 0) && (n_a % 98 == 0));
   endtask

   // Expected pins of dut_b after k_b ticks: latency 3 ticks
   task automatic check_b(input logic ce);
      int p, h, v;
      logic act, e_hs, e_vs;
      h = 0;
      if (k_b < 3) begin
         act = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
      end else begin
         p    = k_b - 3;
         h    = p % 24;
         v    = (p / 24) % 10;
         act  = (h < 16) && (v < 6);
         e_hs = !((h >= 18) && (h < 22));
         e_vs = !((v >= 7) && (v < 9));
      end
      chk("b_col", col_b, k_b % 24);
      chk("b_row", row_b, (k_b / 24) % 10);
      chk("b_hs", hs_b, e_hs);
      chk("b_vs", vs_b, e_vs);
      chk("b_video_on", von_b, act);
      chk("b_r", vga_r_b, act ? 4'(h % 16) : 4'h0);
      chk("b_g", vga_g_b, act ? 4'h7 : 4'h0);
      chk("b_b", vga_b_b, act ? 4'h9 : 4'h0);
      chk("b_line_start", ls_b, ce && (k_b > 0) && (k_b % 24 == 0));
      chk("b_frame_start", fs_b, ce && (k_b > 0) && (k_b % 240 == 0));
   endtask

   // One clk: advance models, run the renderer for dut_b, check both DUTs
   task automatic step();
      logic ce_a_s, ce_b_s;
      int pre_col;
      ce_a_s  = pix_ce_a;
      ce_b_s  = pix_ce_b;
      pre_col = int'(col_b);
      @(posedge clk);
      #1;
      clk_i++;
      if (ce_a_s) n_a++;
      if (ce_b_s) begin
         k_b++;
         h2 = h1;
         h1 = pre_col;
      end
      pix_r_b  = 4'(h2);
      pix_ce_b = ~pix_ce_b;
      check_a(ce_a_s);
      check_b(ce_b_s);
      if (ls_b) begin
         if (last_ls_b >= 0) chk("b_line_period", clk_i - last_ls_b, 48);
         last_ls_b = clk_i;
      end
      if (fs_b) begin
         if (last_fs_b >= 0) chk("b_frame_period", clk_i - last_fs_b, 480);
         last_fs_b = clk_i;
      end
   endtask

   initial begin
      errors = 0; checks = 0;
      n_a = 0; k_b = 0; clk_i = 0; h1 = 0; h2 = 0;
      last_ls_b = -1; last_fs_b = -1;
      rst_n = 1'b0;
      pix_ce_a = 1'b0; pix_ce_b = 1'b0;
      pix_r_a = 4'hF; pix_g_a = 4'hA; pix_b_a = 4'h3;
      pix_r_b = 4'h0; pix_g_b = 4'h7; pix_b_b = 4'h9;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_a(1'b0);
      check_b(1'b0);
      $display("step reset: row_a=%0d col_a=%0d hs_a=%b vs_a=%b", row_a, col_a, hs_a, vs_a);

      @(negedge clk);
      rst_n = 1'b1; pix_ce_a = 1'b1; pix_ce_b = 1'b1;

      // One full frame of dut_a: sync pulse widths
      hs_low = 0; vs_low = 0;
      for (int i = 0; i < 98; i++) begin
         step();
         if (!hs_a) hs_low++;
         if (!vs_a) vs_low++;
      end
      chk("a_hs_low_ticks", hs_low, 14);
      chk("a_vs_low_ticks", vs_low, 14);
      $display("step frame1: hs_low=%0d vs_low=%0d", hs_low, vs_low);

      repeat (50) step();

      // Freeze dut_a mid-line at col 5 for 100 clk
      guard = 0;
      while (col_a != 32'd5 && guard < 50) begin
         step();
         guard++;
      end
      chk("a_reach_col5", col_a, 5);
      pix_ce_a = 1'b0;
      repeat (100) step();
      chk("a_frozen_col", col_a, 5);
      pix_ce_a = 1'b1;
      step();
      chk("a_resume_col", col_a, 6);
      $display("step freeze: resumed at col_a=%0d", col_a);

      // Let dut_b run through several frames
      repeat (1000) step();
      $display("step run: k_b=%0d last_fs_b=%0d", k_b, last_fs_b);

      // Mid-frame reset at row 2, col 7
      guard = 0;
      while (!(row_a == 32'd2 && col_a == 32'd7) && guard < 200) begin
         step();
         guard++;
      end
      chk("a_reach_r2c7", {row_a[15:0], col_a[15:0]}, {16'd2, 16'd7});
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_a_row", row_a, 0);
      chk("rst_a_col", col_a, 0);
      chk("rst_a_hs", hs_a, 1);
      chk("rst_a_vs", vs_a, 1);
      chk("rst_a_rgb", {vga_r_a, vga_g_a, vga_b_a}, 12'h000);
      chk("rst_a_video_on", von_a, 0);
      chk("rst_b_rowcol", {row_b[15:0], col_b[15:0]}, 32'd0);
      $display("step async reset: row_a=%0d col_a=%0d rgb_a=%h", row_a, col_a, {vga_r_a, vga_g_a, vga_b_a});

      n_a = 0; k_b = 0; h1 = 0; h2 = 0;
      pix_r_b = 4'h0; pix_ce_b = 1'b1;
      last_ls_b = -1; last_fs_b = -1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // First frame_start comes one full frame after release
      cnt = 0;
      while (!fs_a && cnt < 200) begin
         step();
         cnt++;
      end
      chk("a_first_fs_ticks", cnt, 98);
      $display("step post-reset: first frame_start after %0d ticks", cnt);

      repeat (10) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
